// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-master SDRAM Avalon-MM arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W_DEF  = 24;
    localparam int DATA_W_DEF  = 16;
    localparam int MASTER_ID_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Synchronous owner-tag FIFO; a push into a full FIFO is honoured when a pop happens in the same cycle.
module sdram_arb_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] dout_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sdram_avalon_arbiter.sv
// Round-robin, bounded-hold arbiter sharing one SDRAM controller slave between two Avalon-MM masters.
module sdram_avalon_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 16,
    parameter int RD_DEPTH = 8
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,
    output logic                err_orphan,
    output logic [1:0]          dbg_state_o
);

    // Handshake: a command transfers in any cycle where mN_read|mN_write is high
    // and mN_waitrequest is low; the master holds the command stable until then.

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] hold_q, hold_d;
    logic [8:0] hold_inc;
    logic       err_orphan_q;

    logic req0, req1, granted, owner;
    logic sel_read, sel_write, sel_req, rd_cmd, rd_block, accept, hold_full;
    logic fifo_full, fifo_empty;
    logic [MASTER_ID_W-1:0] fifo_dout;

    assign req0      = m0_read | m0_write;
    assign req1      = m1_read | m1_write;
    assign granted   = (state_q != ST_IDLE);
    assign owner     = (state_q == ST_OWN1);
    assign sel_read  = owner ? m1_read  : m0_read;
    assign sel_write = owner ? m1_write : m0_write;
    assign sel_req   = sel_read | sel_write;
    assign rd_cmd    = sel_read & ~sel_write;

    // A return in the same cycle frees a slot, so a full FIFO only blocks reads without one.
    assign rd_block  = fifo_full & ~s_readdatavalid;
    assign accept    = granted & sel_req & ~s_waitrequest & ~(rd_cmd & rd_block);

    assign s_address    = granted ? (owner ? m1_address    : m0_address)    : '0;
    assign s_writedata  = granted ? (owner ? m1_writedata  : m0_writedata)  : '0;
    assign s_byteenable = granted ? (owner ? m1_byteenable : m0_byteenable) : '0;
    assign s_write      = granted & sel_write;
    assign s_read       = granted & rd_cmd & ~rd_block;

    assign m0_waitrequest = ~((state_q == ST_OWN0) & accept);
    assign m1_waitrequest = ~((state_q == ST_OWN1) & accept);

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = s_readdatavalid & ~fifo_empty & ~fifo_dout[0];
    assign m1_readdatavalid = s_readdatavalid & ~fifo_empty &  fifo_dout[0];

    assign err_orphan  = err_orphan_q;
    assign dbg_state_o = state_q;

    // Counting the accept in flight makes the grant rotate right after the MAX_HOLD-th accept.
    assign hold_inc  = {1'b0, hold_q} + {8'd0, accept};
    assign hold_full = (hold_inc >= 9'(MAX_HOLD));

    sdram_arb_tag_fifo #(
        .DEPTH(RD_DEPTH),
        .WIDTH(MASTER_ID_W)
    ) u_tag_fifo (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .push_i  (accept & rd_cmd),
        .din_i   (owner),
        .pop_i   (s_readdatavalid),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .dout_o  (fifo_dout)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 && req1)  state_d = last_q ? ST_OWN0 : ST_OWN1;
                else if (req0)     state_d = ST_OWN0;
                else if (req1)     state_d = ST_OWN1;
            end
            ST_OWN0: begin
                if (!req0 || (req1 && hold_full)) begin
                    last_d  = 1'b0;
                    state_d = req1 ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!req1 || (req0 && hold_full)) begin
                    last_d  = 1'b1;
                    state_d = req0 ? ST_OWN0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        hold_d = hold_q;
        if (state_d != state_q)                  hold_d = '0;
        else if (accept && hold_q != 8'(MAX_HOLD)) hold_d = hold_q + 8'd1;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            hold_q       <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            if (s_readdatavalid && fifo_empty) err_orphan_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// Directed bench for sdram_avalon_arbiter with a latency-3 controller model and queue scoreboards.
module tb_sdram_avalon_arbiter;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [23:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
    logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid, err_orphan;
    logic [15:0] s_writedata, s_readdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc;
    int t0;
    int rd0_cnt = 0;
    int rd1_cnt = 0;
    int orphan_req = 0;
    int orphan_ack = 0;
    bit ret_en = 1'b1;
    bit push_cmd = 1'b1;

    logic [15:0] exp_rd0_q[$];
    logic [15:0] exp_rd1_q[$];
    logic [42:0] exp_cmd_q[$];
    int          acc_cyc_q[$];
    int          rdv_cyc_q[$];
    int          ret_due_q[$];
    logic [15:0] ret_dat_q[$];

    always #5 clk_clk = ~clk_clk;

    sdram_avalon_arbiter #(.ADDR_W(24), .DATA_W(16), .MAX_HOLD(4), .RD_DEPTH(8)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .err_orphan(err_orphan),
        .dbg_state_o(dbg_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Clock/reset bookkeeping: cyc counts cycles since reset release.
    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) cyc <= 0;
        else                cyc <= cyc + 1;
    end

    // Controller model: returns address[15:0] three cycles after an accepted read.
    always @(posedge clk_clk) begin
        #1;
        if (!reset_reset_n) begin
            s_readdatavalid = 1'b0;
        end else if (ret_en && ret_due_q.size() > 0 && ret_due_q[0] <= cyc) begin
            s_readdatavalid = 1'b1;
            s_readdata      = ret_dat_q.pop_front();
            void'(ret_due_q.pop_front());
        end else if (orphan_req != orphan_ack) begin
            s_readdatavalid = 1'b1;
            s_readdata      = 16'hDEAD;
            orphan_ack++;
        end else begin
            s_readdatavalid = 1'b0;
            s_readdata      = 16'h0000;
        end
    end

    // Monitor: command scoreboard on the slave side, read-return scoreboards per master.
    always @(negedge clk_clk) begin
        if (reset_reset_n) begin
            if ((s_read || s_write) && !s_waitrequest) begin
                acc_cyc_q.push_back(cyc);
                if (exp_cmd_q.size() == 0) fail_now("unexpected_s_cmd");
                else chk("s_cmd", {s_write, s_address, s_writedata, s_byteenable}, exp_cmd_q.pop_front());
                if (s_read) begin
                    ret_due_q.push_back(cyc + 3);
                    ret_dat_q.push_back(s_address[15:0]);
                end
            end
            if (m0_readdatavalid) begin
                rd0_cnt++;
                rdv_cyc_q.push_back(cyc);
                if (exp_rd0_q.size() == 0) fail_now("unexpected_m0_readdatavalid");
                else chk("m0_readdata", m0_readdata, exp_rd0_q.pop_front());
            end
            if (m1_readdatavalid) begin
                rd1_cnt++;
                rdv_cyc_q.push_back(cyc);
                if (exp_rd1_q.size() == 0) fail_now("unexpected_m1_readdatavalid");
                else chk("m1_readdata", m1_readdata, exp_rd1_q.pop_front());
            end
        end
    end

    // Driver: present one command and hold it until accepted; returns at posedge+1.
    task automatic do_cmd(input int m, input logic wr, input logic [23:0] a,
                          input logic [15:0] d, input logic [1:0] be);
        int   n;
        logic w;
        if (m == 0) begin
            m0_address = a; m0_write = wr; m0_read = ~wr; m0_writedata = d; m0_byteenable = be;
            if (!wr) exp_rd0_q.push_back(a[15:0]);
        end else begin
            m1_address = a; m1_write = wr; m1_read = ~wr; m1_writedata = d; m1_byteenable = be;
            if (!wr) exp_rd1_q.push_back(a[15:0]);
        end
        if (push_cmd) exp_cmd_q.push_back({wr, a, d, be});
        n = 0;
        do begin
            @(negedge clk_clk);
            w = (m == 0) ? m0_waitrequest : m1_waitrequest;
            n++;
        end while (w && n < 200);
        if (w) fail_now("cmd_accept_timeout");
        @(posedge clk_clk);
        #1;
    endtask

    task automatic idle_m(input int m);
        if (m == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
        else        begin m1_read = 1'b0; m1_write = 1'b0; end
    endtask

    task automatic clear_logs();
        acc_cyc_q.delete();
        rdv_cyc_q.delete();
        rd0_cnt = 0;
        rd1_cnt = 0;
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        exp_rd0_q.delete(); exp_rd1_q.delete(); exp_cmd_q.delete();
        ret_due_q.delete(); ret_dat_q.delete();
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(posedge clk_clk);
        #1;
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while (acc_cyc_q.size() < n && k < 100) begin
            @(negedge clk_clk);
            k++;
        end
        if (acc_cyc_q.size() < n) fail_now("wait_accept_timeout");
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_rd0_q.size() + exp_rd1_q.size() + ret_due_q.size()) > 0 && k < 100) begin
            @(negedge clk_clk);
            k++;
        end
        if ((exp_rd0_q.size() + exp_rd1_q.size() + ret_due_q.size()) > 0) fail_now("read_drain_timeout");
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m0_waitrequest"}, m0_waitrequest, 1'b1);
        chk({tag, "_m1_waitrequest"}, m1_waitrequest, 1'b1);
        chk({tag, "_s_cmd"}, {s_read, s_write, s_address, s_writedata, s_byteenable}, 60'h0);
        chk({tag, "_readdatavalid"}, {m0_readdatavalid, m1_readdatavalid}, 2'b00);
        chk({tag, "_err_orphan"}, err_orphan, 1'b0);
        chk({tag, "_state"}, dbg_state, 2'd0);
    endtask

    initial begin
        reset_reset_n = 1'b0;
        {m0_address, m0_read, m0_write, m0_writedata, m0_byteenable} = '0;
        {m1_address, m1_read, m1_write, m1_writedata, m1_byteenable} = '0;
        s_waitrequest = 1'b0;
        s_readdatavalid = 1'b0;
        s_readdata = 16'h0;
        repeat (3) @(posedge clk_clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(posedge clk_clk);
        #1;

        // Single master: 4 writes then 4 reads, accepts in 8 consecutive cycles from t0+1.
        clear_logs();
        t0 = cyc;
        for (int i = 0; i < 4; i++) do_cmd(0, 1'b1, 24'h000010 + 24'(i), 16'hA000 + 16'(i), 2'b11);
        for (int i = 0; i < 4; i++) do_cmd(0, 1'b0, 24'h000010 + 24'(i), 16'h0000, 2'b11);
        idle_m(0);
        drain();
        chk("single_accept_count", acc_cyc_q.size(), 8);
        for (int i = 0; i < acc_cyc_q.size(); i++) chk("single_accept_cycle", acc_cyc_q[i], t0 + 1 + i);
        chk("single_m0_rdv_count", rd0_cnt, 4);
        chk("single_m1_rdv_count", rd1_cnt, 0);

        // Interleaved reads: m0 gets 1111 then 3333, m1 gets 2222.
        clear_logs();
        do_cmd(0, 1'b0, 24'h001111, 16'h0, 2'b11); idle_m(0);
        do_cmd(1, 1'b0, 24'h002222, 16'h0, 2'b11); idle_m(1);
        do_cmd(0, 1'b0, 24'h003333, 16'h0, 2'b11); idle_m(0);
        drain();
        chk("inter_m0_rdv_count", rd0_cnt, 2);
        chk("inter_m1_rdv_count", rd1_cnt, 1);

        // Tie and fairness with MAX_HOLD=4: grants alternate every 4 accepts, no gaps.
        do_reset();
        clear_logs();
        push_cmd = 1'b0;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 4; i++) begin
                logic [23:0] a;
                a = ((s % 2) == 0) ? 24'h000100 : 24'h000200;
                a = a + 24'((s / 2) * 4 + i);
                exp_cmd_q.push_back({1'b1, a, (((s % 2) == 0) ? 16'hC000 : 16'hD000) + 16'((s / 2) * 4 + i), 2'b11});
            end
        t0 = cyc;
        fork
            begin
                for (int i = 0; i < 8; i++) do_cmd(0, 1'b1, 24'h000100 + 24'(i), 16'hC000 + 16'(i), 2'b11);
                idle_m(0);
            end
            begin
                for (int i = 0; i < 8; i++) do_cmd(1, 1'b1, 24'h000200 + 24'(i), 16'hD000 + 16'(i), 2'b11);
                idle_m(1);
            end
        join
        push_cmd = 1'b1;
        chk("fair_accept_count", acc_cyc_q.size(), 16);
        for (int i = 0; i < acc_cyc_q.size(); i++) chk("fair_accept_cycle", acc_cyc_q[i], t0 + 1 + i);

        // FIFO full: 8 reads accepted, then stall until the first return frees a slot.
        clear_logs();
        ret_en = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) do_cmd(0, 1'b0, 24'h000400 + 24'(i), 16'h0, 2'b11);
                idle_m(0);
            end
            begin
                wait_acc(8);
                repeat (3) @(negedge clk_clk);
                chk("full_accept_count", acc_cyc_q.size(), 8);
                chk("full_m0_waitrequest", m0_waitrequest, 1'b1);
                chk("full_s_read", s_read, 1'b0);
                ret_en = 1'b1;
            end
        join
        drain();
        chk("full_total_accepts", acc_cyc_q.size(), 10);
        if (acc_cyc_q.size() > 8 && rdv_cyc_q.size() > 0)
            chk("full_push_pop_same_cycle", acc_cyc_q[8], rdv_cyc_q[0]);
        else
            fail_now("full_push_pop_same_cycle_missing");
        chk("full_m0_rdv_count", rd0_cnt, 10);

        // Orphan return, then a stalled m1 write.
        clear_logs();
        @(negedge clk_clk);
        chk("pre_orphan_err", err_orphan, 1'b0);
        orphan_req++;
        @(negedge clk_clk);
        chk("orphan_readdatavalid", {s_readdatavalid, m0_readdatavalid, m1_readdatavalid}, 3'b100);
        @(negedge clk_clk);
        chk("orphan_err_set", err_orphan, 1'b1);
        @(posedge clk_clk);
        #1;
        s_waitrequest = 1'b1;
        fork
            do_cmd(1, 1'b1, 24'h0ABCDE, 16'h5A5A, 2'b01);
            begin
                @(negedge clk_clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk_clk);
                    chk("stall_m1_waitrequest", m1_waitrequest, 1'b1);
                    chk("stall_s_cmd", {s_read, s_write, s_address, s_writedata, s_byteenable},
                        {1'b0, 1'b1, 24'h0ABCDE, 16'h5A5A, 2'b01});
                end
                @(posedge clk_clk);
                #1;
                s_waitrequest = 1'b0;
            end
        join
        idle_m(1);
        chk("stall_accept_count", acc_cyc_q.size(), 1);
        chk("orphan_err_sticky", err_orphan, 1'b1);

        // Reset with three reads outstanding.
        clear_logs();
        ret_en = 1'b0;
        for (int i = 0; i < 3; i++) do_cmd(0, 1'b0, 24'h000500 + 24'(i), 16'h0, 2'b11);
        idle_m(0);
        #2;
        reset_reset_n = 1'b0;
        exp_rd0_q.delete(); exp_rd1_q.delete(); exp_cmd_q.delete();
        ret_due_q.delete(); ret_dat_q.delete();
        #1;
        chk_reset_outputs("midreset");
        ret_en = 1'b1;
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(posedge clk_clk);
        #1;
        @(negedge clk_clk);
        orphan_req++;
        @(negedge clk_clk);
        chk("post_reset_fifo_empty_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
        @(negedge clk_clk);
        chk("post_reset_orphan_err", err_orphan, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdram_avalon_arbiter.md
# sdram_avalon_arbiter

Two-master Avalon-MM arbiter that shares the single SDRAM controller slave port (24-bit word address, 16-bit data, 2-bit byteenable) between the Nios II data master (m0) and a streaming requester such as a DMA or video reader (m1). It sits between the masters and the SDRAM controller's Avalon slave, in the PLL system-clock domain that also clocks the controller. Arbitration is round-robin with a bounded hold. Read responses are routed back in order through an owner-tag FIFO, because the controller returns pipelined `readdatavalid`.

## Interface
- `ADDR_W`, default 24: word address width (13 row + 9 col + 2 bank).
- `DATA_W`, default 16: data width; byteenable width is `DATA_W/8`.
- `MAX_HOLD`, default 16: accepted commands before a contested grant must rotate; range 1..255.
- `RD_DEPTH`, default 8: outstanding-read tag FIFO depth; must be a power of 2 and ≥ the controller's maximum pending reads.
- `clk_clk` in, 1: system clock.
- `reset_reset_n` in, 1: reset. One clock; reset is asynchronous and active-low.
- `mN_address` in, ADDR_W (N=0,1): master word address.
- `mN_read`, `mN_write` in, 1: command strobes. Both high at once is illegal; the write takes priority.
- `mN_writedata` in, DATA_W: write data.
- `mN_byteenable` in, DATA_W/8: byte enables.
- `mN_waitrequest` out, 1: stall to the master.
- `mN_readdata` out, DATA_W: read data, broadcast to both masters.
- `mN_readdatavalid` out, 1: read return, steered to the owning master.
- `s_address`, `s_read`, `s_write`, `s_writedata`, `s_byteenable` out: command to the SDRAM controller.
- `s_waitrequest` in, 1: controller stall.
- `s_readdata` in, DATA_W: controller read data.
- `s_readdatavalid` in, 1: controller read valid.
- `err_orphan` out, 1: sticky flag, set by a read return arriving while the tag FIFO is empty.

## Operation
- State machine has three states: IDLE, OWN0, OWN1. Grant is registered, and the command mux is combinational from the registered grant.
- `reqN` = `mN_read | mN_write`.
- `accept` = granted master's req & ~`s_waitrequest` & ~(read & tag FIFO full).
- **IDLE.** Both `mN_waitrequest`=1 and `s_read`=`s_write`=0.
  - Only one master requesting: next state is that master's OWN.
  - Both requesting: next state is OWN for the master that is not `last`.
- **OWNx, command path.**
  - The slave command equals master x's command.
  - `mx_waitrequest` = ~accept while `reqx`=1.
  - The other master's waitrequest is 1.
  - `s_read` is forced 0 while the FIFO is full.
- **OWNx, hold counter.** Increments on each accept and clears on every grant change.
- **OWNx, release.** Release when `reqx`=0, or when the hold counter reaches MAX_HOLD and the other master is requesting.
  - On release, `last` becomes x.
  - Next state is OWNy if `reqy`=1, else IDLE.
  - Release is evaluated on registered state, so a rotation takes effect the cycle after the MAX_HOLD-th accept.
- **Tag FIFO.** An accepted read pushes the owner bit x. Each `s_readdatavalid` pops, and the popped bit selects which `mN_readdatavalid` pulses. A push and a pop in the same cycle are both honoured.
- **Orphan return.** `s_readdatavalid` with the FIFO empty sets `err_orphan`, the return is dropped, and neither readdatavalid asserts. `err_orphan` clears only on reset.
- **Writes** push no tag.

## Timing
- **Reset values:**
  - State IDLE, `last`=1 (so m0 wins the first tie).
  - Hold counter 0, FIFO empty, `err_orphan`=0.
  - All `s_*` command outputs 0.
  - Both `mN_waitrequest`=1, both `mN_readdatavalid`=0.
- **Arbitration latency.** A request in IDLE at cycle t gets its grant at t+1. The earliest accept is at t+1 if `s_waitrequest`=0.
- **Back-to-back accepts.** A granted master can have one command accepted per cycle with zero bubbles.
- **Read return path.** Combinational, 0 cycles: `mN_readdatavalid` and `mN_readdata` follow `s_readdatavalid` and `s_readdata` in the same cycle.
- **Rotation gap.** When switching OWN0→OWN1 there is no IDLE cycle. The new master can have a command accepted in the first cycle of its grant.
- **Reset mid-operation.** Asynchronous return to the reset values. Any in-flight controller reads become orphans; this is expected, and the controller is reset from the same `reset_reset_n`.

## Structure
- **Package `sdram_arb_pkg`.** Holds the state enum (IDLE, OWN0, OWN1), the `ADDR_W`/`DATA_W` defaults, and the `MASTER_ID` width constant (1).
- **Sub-module `sdram_arb_tag_fifo`.** A 1-bit-wide synchronous FIFO of depth RD_DEPTH with push, pop, full, empty and dout. It is reusable for wider master counts.
- **Arbiter FSM, hold counter and mux** stay in the top module.

## Test plan
- **Single master.** m0 issues 4 writes then 4 reads to 0x000010..13 with `s_waitrequest`=0 and the controller returning reads 3 cycles later. Expect the grant at cycle 1, 8 accepts in 8 consecutive cycles, 4 `m0_readdatavalid` pulses in order, and `m1_readdatavalid` never asserted.
- **Tie and fairness.** Both masters request continuously from reset, MAX_HOLD=4. Expect the grant sequence OWN0 (4 accepts), OWN1 (4 accepts), OWN0, and so on, with no IDLE cycles in between.
- **Interleaved reads.** m0 reads A, m1 reads B and m0 reads C, with returns 0x1111, 0x2222 and 0x3333. Expect m0 to receive 0x1111 and then 0x3333, and m1 to receive 0x2222.
- **FIFO full.** RD_DEPTH=8 with no returns; m0 issues 10 reads. Expect exactly 8 accepts, `m0_waitrequest`=1 and `s_read`=0 afterwards, and the 9th read accepted in the same cycle as the first return (push and pop together).
- **Orphan and stall.** Pulse `s_readdatavalid` with the FIFO empty: expect `err_orphan`=1 and no master readdatavalid. Then hold `s_waitrequest`=1 for 5 cycles during an m1 write: expect `m1_waitrequest`=1 throughout and the write stable on `s_*`.
- **Reset mid-burst.** Assert `reset_reset_n`=0 with 3 reads outstanding. Expect all outputs at their reset values immediately and the FIFO empty after release.
